// File: rtl/crypto_bus_pkg.sv
// Shared types and port IDs for the crypto bus switch.
package crypto_bus_pkg;

  // Channel ownership phases
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    DROP     = 2'd2,
    ACK_WAIT = 2'd3
  } state_t;

  // Engine port IDs on the default 4-port build
  localparam int AES  = 0;
  localparam int SHA  = 1;
  localparam int CTRL = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request searching upward from ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any_req
);

  logic [31:0] idx;

  // Scan offsets high-to-low so the lowest offset from ptr wins last
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    any_req = |req;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % 32'(N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/crypto_bus_switch.sv
// Shared packet channel: round-robin source grant, cut-through routing to one
// destination, then end-to-end ack (or timeout) reported back as done/err.
module crypto_bus_switch
  import crypto_bus_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int ACK_TMO = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*DATA_W-1:0] req_data,
  input  logic [N_PORTS*ID_W-1:0]   req_dest,
  input  logic [N_PORTS-1:0]        req_last,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_src,
  output logic                      out_last,
  input  logic [N_PORTS-1:0]        out_ready,
  input  logic [N_PORTS-1:0]        ack_in,
  output logic [N_PORTS-1:0]        done,
  output logic                      err,
  output logic                      busy
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(ACK_TMO + 1);

  state_t             state;
  logic [ID_W-1:0]    gnt, dst;
  logic [PW-1:0]      rr_ptr;
  logic [CW-1:0]      cnt;

  logic [N_PORTS-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;

  logic [ID_W-1:0]    new_dst;
  logic               new_bad;
  logic               src_valid, src_last, dst_ready, dst_ack;
  logic [DATA_W-1:0]  src_data;
  logic [N_PORTS-1:0] gnt_oh;

  rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // Destination of the newly granted source; self or out-of-range goes to DROP
  always_comb begin
    new_dst = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (arb_gnt[i]) new_dst = req_dest[i*ID_W +: ID_W];
    new_bad = (32'(new_dst) >= 32'(N_PORTS)) || (new_dst == ID_W'(arb_idx));
  end

  // Select the owning source's beat and the destination's ready/ack
  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = '0;
    dst_ready = 1'b0;
    dst_ack   = 1'b0;
    gnt_oh    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (ID_W'(i) == gnt) begin
        src_valid = req_valid[i];
        src_last  = req_last[i];
        src_data  = req_data[i*DATA_W +: DATA_W];
        gnt_oh[i] = 1'b1;
      end
      if (ID_W'(i) == dst) begin
        dst_ready = out_ready[i];
        dst_ack   = ack_in[i];
      end
    end
  end

  // Cut-through routing: zero-latency valid/ready path while owning the channel
  always_comb begin
    req_ready = '0;
    out_valid = '0;
    out_data  = '0;
    out_src   = '0;
    out_last  = 1'b0;
    case (state)
      XFER: begin
        for (int i = 0; i < N_PORTS; i++) begin
          if (ID_W'(i) == dst) out_valid[i] = src_valid;
          if (ID_W'(i) == gnt) req_ready[i] = dst_ready;
        end
        out_data = src_data;
        out_last = src_last;
        out_src  = gnt;
      end
      DROP:    req_ready = gnt_oh;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // Channel FSM with registered done/err status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      dst    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: if (arb_any) begin
          gnt    <= ID_W'(arb_idx);
          dst    <= new_dst;
          rr_ptr <= (arb_idx == PW'(N_PORTS - 1)) ? '0 : arb_idx + 1'b1;
          state  <= new_bad ? DROP : XFER;
        end
        XFER: if (src_valid && dst_ready && src_last) begin
          state <= ACK_WAIT;
          cnt   <= '0;
        end
        DROP: if (src_valid && src_last) begin
          done  <= gnt_oh;
          err   <= 1'b1;
          state <= IDLE;
        end
        ACK_WAIT: begin
          if (dst_ack) begin
            done  <= gnt_oh;
            state <= IDLE;
          end else if (cnt == CW'(ACK_TMO - 1)) begin
            done  <= gnt_oh;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_bus_switch.sv
// Self-checking bench for crypto_bus_switch: directed scenarios plus random
// packets checked against a packet-level reference model.
module tb_crypto_bus_switch;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, out_valid, out_ready, ack_in, done;
  logic [N*DW-1:0] req_data;
  logic [N*IW-1:0] req_dest;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_src;
  logic            out_last, err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;  // reference round-robin pointer

  always #5 clk = ~clk;

  crypto_bus_switch #(.N_PORTS(N), .DATA_W(DW), .ID_W(IW), .ACK_TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_ready(out_ready), .ack_in(ack_in),
    .done(done), .err(err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0; req_data = '0; req_dest = '0;
    ack_in = '0; out_ready = '1;
  endtask

  // First requester at or above ptr, wrapping
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // One packet from a lone requester. ack_dly: cycles into ACK_WAIT before the
  // ack pulse (<0 = never). bp_mode: 0 ready, 1 random, 2 pattern 1,0,0,1.
  task automatic do_pkt(input int src, input int dest, input int n, input int ack_dly,
                        input int bp_mode, input bit gaps, input int base);
    logic [DW-1:0] d[$];
    logic [N-1:0]  exp_rdy, exp_ov;
    bit good, v;
    int beat, guard, bpi;
    good = (dest != src) && (dest < N);
    for (int i = 0; i < n; i++) d.push_back(base >= 0 ? DW'(base + i) : DW'($urandom));
    tick();
    req_valid[src] = 1'b1;
    req_dest[src*IW +: IW] = IW'(dest);
    req_data[src*DW +: DW] = d[0];
    req_last[src] = (n == 1);
    @(negedge clk);
    chk("grant_busy", busy, 0);
    chk("grant_ready", req_ready, 0);
    tick();
    m_ptr = (src + 1) % N;
    beat = 0; guard = 0; bpi = 0;
    while (beat < n && guard < 200) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      req_valid[src] = v;
      req_data[src*DW +: DW] = d[beat];
      req_last[src] = (beat == n - 1);
      case (bp_mode)
        0:       out_ready = '1;
        1:       out_ready = N'($urandom);
        default: out_ready = {N{(bpi % 4 == 0) || (bpi % 4 == 3)}};
      endcase
      bpi++;
      exp_rdy = '0; exp_ov = '0;
      if (good) begin
        if (out_ready[dest]) exp_rdy[src] = 1'b1;
        if (v) exp_ov[dest] = 1'b1;
      end else begin
        exp_rdy[src] = 1'b1;
      end
      @(negedge clk);
      chk(good ? "xfer_out_valid" : "drop_out_valid", out_valid, exp_ov);
      chk(good ? "xfer_req_ready" : "drop_req_ready", req_ready, exp_rdy);
      chk("owned_busy", busy, 1);
      chk("owned_no_done", done, 0);
      if (good && v) begin
        chk("xfer_data", out_data, d[beat]);
        chk("xfer_last", out_last, beat == n - 1);
        chk("xfer_src", out_src, src);
      end
      tick();
      if (v && exp_rdy[src]) beat++;
      guard++;
    end
    chk("xfer_budget", guard < 200, 1);
    req_valid[src] = 1'b0; req_last[src] = 1'b0; out_ready = '1;
    if (!good) begin
      @(negedge clk);
      chk("drop_done", done, 1 << src);
      chk("drop_err", err, 1);
      chk("drop_idle", busy, 0);
    end else begin
      for (int k = 0; k < TMO; k++) begin
        ack_in = N'($urandom) & ~(N'(1) << dest);
        if (k == ack_dly) ack_in[dest] = 1'b1;
        @(negedge clk);
        chk("ackwait_busy", busy, 1);
        chk("ackwait_no_done", done, 0);
        chk("ackwait_out_valid", out_valid, 0);
        tick();
        ack_in = '0;
        if (k == ack_dly) break;
      end
      @(negedge clk);
      chk("ack_done", done, 1 << src);
      chk("ack_err", err, (ack_dly >= 0 && ack_dly < TMO) ? 0 : 1);
      chk("ack_idle", busy, 0);
    end
    ack_in = '0;
    tick();
    @(negedge clk);
    chk("done_pulse_clr", done, 0);
    chk("err_clr", err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, s, dd, nb, ad;
    logic [IW-1:0] fdst [N];

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    m_ptr = 0;

    // Fairness: ports 0,1,3 request continuously, single beats, immediate ack
    fdst[0] = 1; fdst[1] = 0; fdst[2] = 0; fdst[3] = 0;
    req_valid = 4'b1011; req_last = 4'b1011;
    for (int i = 0; i < N; i++) begin
      req_dest[i*IW +: IW] = fdst[i];
      req_data[i*DW +: DW] = DW'(8'h30 + i);
    end
    for (int p = 0; p < 6; p++) begin
      e = pick(req_valid, m_ptr);
      tick();
      m_ptr = (e + 1) % N;
      @(negedge clk);
      chk("fair_grant", req_ready, 1 << e);
      chk("fair_src", out_src, e);
      chk("fair_data", out_data, 8'h30 + e);
      tick();
      ack_in = '0;
      ack_in[fdst[e]] = 1'b1;
      @(negedge clk);
      chk("fair_ackwait", busy, 1);
      tick();
      ack_in = '0;
      @(negedge clk);
      chk("fair_done", done, 1 << e);
      chk("fair_err", err, 0);
    end
    idle_inputs();

    // Directed packets
    do_pkt(1, 0, 3, 1, 0, 1'b0, 8'hA1);    // SHA -> AES, 3 beats
    do_pkt(1, 0, 4, 0, 2, 1'b0, -1);       // backpressure 1,0,0,1
    do_pkt(2, 2, 2, 0, 0, 1'b0, -1);       // self destination
    do_pkt(3, 1, 2, -1, 0, 1'b0, -1);      // ack timeout
    do_pkt(0, 3, 1, TMO - 1, 0, 1'b0, -1); // ack on the timeout cycle

    // Reset during XFER after beat 1 of 3
    tick();
    req_valid[1] = 1'b1; req_dest[1*IW +: IW] = 2'd0; req_data[1*DW +: DW] = 8'hB1; req_last[1] = 1'b0;
    tick();
    @(negedge clk);
    chk("rx_beat1_valid", out_valid, 4'b0001);
    tick();
    req_data[1*DW +: DW] = 8'hB2;
    rst = 1'b1;
    #1;
    chk("rx_out_valid", out_valid, 0);
    chk("rx_req_ready", req_ready, 0);
    chk("rx_busy", busy, 0);
    chk("rx_done", done, 0);
    chk("rx_out_data", out_data, 0);
    chk("rx_out_src", out_src, 0);
    idle_inputs();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    req_valid = 4'b1001; req_last = 4'b1001;
    req_dest[0*IW +: IW] = 2'd2; req_dest[3*IW +: IW] = 2'd1;
    e = pick(req_valid, m_ptr);
    tick();
    m_ptr = (e + 1) % N;
    @(negedge clk);
    chk("rx_regrant", req_ready, 1 << e);
    chk("rx_no_done", done, 0);
    tick();
    idle_inputs();
    ack_in[fdst[0] + 1] = 1'b1;  // port 0 targets dest 2
    @(negedge clk);
    tick();
    ack_in = '0;
    @(negedge clk);
    chk("rx_done_after", done, 1 << e);
    chk("rx_err_after", err, 0);

    // Random packets
    for (int r = 0; r < 40; r++) begin
      s  = $urandom_range(0, N - 1);
      dd = $urandom_range(0, N - 1);
      nb = $urandom_range(1, 4);
      case ($urandom_range(0, 9))
        0:       ad = -1;
        1:       ad = TMO - 1;
        default: ad = $urandom_range(0, 5);
      endcase
      do_pkt(s, dd, nb, ad, 1, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
